pipe_ctrl_skid_reg: RTL and testbench
=====================================

# pipe_ctrl_skid_reg

Parametrised pipeline-boundary register for the control bundle passed between stages (ID/EX, EX/MEM, MEM/WB). It replaces free-running capture-every-clock stage registers with a valid/ready handshake and a two-entry skid buffer, so a downstream stall never drops a control word. It also adds a flush that squashes in-flight entries and drives a NOP bundle whenever the stage is empty. One instance sits at each stage boundary of the control path.

## Interface
- `DATA_W`, 12, width of the packed control bundle (write enables, read enable, mux selects, ALU control, status bit, size).
- `NOP_VALUE`, all-zero, bundle driven on `out_data` when `out_valid`=0; all enables are inactive.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Asserting it clears all state immediately; release is synchronous to `clk`.
- `in_valid` in 1: upstream holds a control word.
- `in_ready` out 1: block accepts a word this cycle. Registered, with no combinational path from `out_ready`.
- `in_data` in DATA_W: incoming control bundle.
- `out_valid` out 1: `out_data` holds a live word.
- `out_ready` in 1: downstream consumes the word. Low means stall.
- `out_data` out DATA_W: head word, or `NOP_VALUE` when empty.
- `flush` in 1: squash all held words (branch taken, exception).
- `occupancy` out 2: number of held entries, 0..2.

## Operation
- Fire definitions:
  - in_fire = `in_valid` & `in_ready`
  - out_fire = `out_valid` & `out_ready`
- State is the occupancy: EMPTY (0), ONE (1), TWO (2). Storage is a main register (head) and a skid register.
- EMPTY:
  - in_fire loads main and moves to ONE.
- ONE:
  - in_fire only: loads skid and moves to TWO.
  - out_fire only: moves to EMPTY.
  - Both: main <= `in_data`, stays in ONE.
- TWO:
  - `in_ready`=0, so no in_fire can occur.
  - out_fire: main <= skid, moves to ONE.
- `in_ready` = (next occupancy < 2), registered.
- `out_valid` = (occupancy != 0).
- `out_data` = main when valid, otherwise `NOP_VALUE`. No X or stale bundle is ever driven while invalid.
- `flush` overrides everything in its cycle:
  - Next occupancy = 0, and any in_fire that cycle is discarded.
  - `in_ready` is 1 the following cycle.
  - An out_fire in the flush cycle still counts as consumed downstream. The block takes no action on it.
- Ordering is strict FIFO: words leave in acceptance order, with no duplication or loss absent flush.
- Reset values:
  - `out_valid`=0, `out_data`=`NOP_VALUE`, `occupancy`=0, `in_ready`=1.
  - Main and skid registers hold `NOP_VALUE`.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `out_data` after edge N, and out_fire is possible in cycle N+1.
- Sustained throughput is 1 word per cycle while `out_ready`=1.
- A stall (`out_ready`=0) while in ONE absorbs exactly one more word.
- `in_ready` falls at the edge on which occupancy becomes 2, i.e. one cycle after the downstream stall is visible. This is the purpose of the skid.
- After `out_ready` returns high in TWO:
  - Skid data is on `out_data` one cycle later.
  - `in_ready` rises at that same edge.
- Flush takes effect at the next edge: `out_valid`=0 and `out_data`=`NOP_VALUE` after that edge.
- Reset asserted mid-operation:
  - Outputs go to reset values asynchronously, without waiting for a clock edge.
  - No word survives.
  - The first acceptance is possible on the first edge after release.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - Control-bundle field offsets and widths.
  - The `NOP` bundle constant.
  - The default `DATA_W`.
- Stage instances pack and unpack the bundle using the package offsets.
- No sub-module: one occupancy register, two data registers and registered `in_ready` live in a single module.

## Test plan
- **Streaming:** `out_ready`=1 held; push 0x001..0x00A back-to-back → identical sequence out, each one cycle after acceptance; `occupancy` never exceeds 1.
- **Stall absorb:** push 0x0A5 and 0x05A while `out_ready`=0 → `occupancy`=2 and `in_ready`=0 after the second edge; raise `out_ready` → 0x0A5 then 0x05A, with `in_ready` back to 1 after the first out_fire.
- **Simultaneous fire in ONE:** main=0x111, in_fire of 0x222 in the same cycle as out_fire → next cycle `out_data`=0x222, `occupancy`=1.
- **Flush:**
  - Flush while `occupancy`=2 → next cycle `out_valid`=0, `out_data`=0x000, `occupancy`=0, `in_ready`=1.
  - Word 0x333 offered during the flush cycle never appears on the output.
- **Async reset mid-stream:** `reset` low between edges while in TWO → outputs at reset values before the next edge; after release, push 0x7FF → emerges one cycle later.
- **Random scoreboard:** random `in_valid`/`out_ready`/sparse `flush` for 10k cycles → FIFO order preserved, no loss without flush, `out_data`=`NOP_VALUE` whenever `out_valid`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle layout for the pipeline-boundary registers.
// Field offsets, widths, the NOP bundle and pack/unpack helpers.
package pipe_ctrl_pkg;

   localparam int unsigned CTRL_DATA_W = 12;

   localparam int unsigned REG_WE_OFF  = 0;
   localparam int unsigned MEM_WE_OFF  = 1;
   localparam int unsigned MEM_RE_OFF  = 2;
   localparam int unsigned WB_SEL_OFF  = 3;
   localparam int unsigned WB_SEL_W    = 2;
   localparam int unsigned ALU_SRC_OFF = 5;
   localparam int unsigned ALU_OP_OFF  = 6;
   localparam int unsigned ALU_OP_W    = 4;
   localparam int unsigned STATUS_OFF  = 10;
   localparam int unsigned SIZE_OFF    = 11;

   // MSB-first so the struct bit positions match the offsets above
   typedef struct packed {
      logic                size;
      logic                status;
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_src;
      logic [WB_SEL_W-1:0] wb_sel;
      logic                mem_re;
      logic                mem_we;
      logic                reg_we;
   } ctrl_bundle_t;

   // All enables inactive
   localparam ctrl_bundle_t CTRL_NOP = '0;

   function automatic logic [CTRL_DATA_W-1:0] ctrl_pack(input ctrl_bundle_t b);
      return CTRL_DATA_W'(b);
   endfunction

   function automatic ctrl_bundle_t ctrl_unpack(input logic [CTRL_DATA_W-1:0] v);
      ctrl_bundle_t b;
      b         = CTRL_NOP;
      b.reg_we  = v[REG_WE_OFF];
      b.mem_we  = v[MEM_WE_OFF];
      b.mem_re  = v[MEM_RE_OFF];
      b.wb_sel  = v[WB_SEL_OFF +: WB_SEL_W];
      b.alu_src = v[ALU_SRC_OFF];
      b.alu_op  = v[ALU_OP_OFF +: ALU_OP_W];
      b.status  = v[STATUS_OFF];
      b.size    = v[SIZE_OFF];
      return b;
   endfunction

endpackage

// File: rtl/pipe_ctrl_skid_reg.sv
// Valid/ready stage register with a two-entry skid and flush for the control path.
// The head register is kept at NOP_VALUE whenever the stage is empty, so out_data is a flop.
module pipe_ctrl_skid_reg
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned       DATA_W    = CTRL_DATA_W,
   parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(CTRL_NOP)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt;
   logic [DATA_W-1:0] skid_q, skid_nxt;
   logic              in_ready_q, in_ready_nxt;
   logic              out_valid_q, out_valid_nxt;
   logic              in_fire, out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   // State, storage and registered handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= EMPTY;
         main_q      <= NOP_VALUE;
         skid_q      <= NOP_VALUE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         main_q      <= main_nxt;
         skid_q      <= skid_nxt;
         in_ready_q  <= in_ready_nxt;
         out_valid_q <= out_valid_nxt;
      end
   end

   // Next occupancy and data movement; flush wins over any fire
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;

      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = NOP_VALUE;
         skid_nxt  = NOP_VALUE;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_nxt  = in_data;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire) begin
                  skid_nxt  = in_data;
                  state_nxt = TWO;
               end else if (out_fire) begin
                  main_nxt  = NOP_VALUE;
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_nxt  = skid_q;
                  skid_nxt  = NOP_VALUE;
                  state_nxt = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
               main_nxt  = NOP_VALUE;
               skid_nxt  = NOP_VALUE;
            end
         endcase
      end

      in_ready_nxt  = (state_nxt != TWO);
      out_valid_nxt = (state_nxt != EMPTY);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state;

endmodule

// File: tb/tb_pipe_ctrl_skid_reg.sv
// Scoreboard bench: a queue model of the stage tracks accepted words, a monitor checks the DUT.
module tb_pipe_ctrl_skid_reg;
   import pipe_ctrl_pkg::*;

   localparam int unsigned W = CTRL_DATA_W;
   localparam logic [W-1:0] NOP = '0;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic          flush = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;

   int            tests = 0;
   int            fails = 0;
   logic [W-1:0]  sb_q[$];
   bit            m_in_ready = 1'b1;

   always #5 clk = ~clk;

   pipe_ctrl_skid_reg #(.DATA_W(W), .NOP_VALUE(NOP)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .flush(flush), .occupancy(occupancy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model update: a bounded FIFO of accepted words, cleared by flush or reset
   always @(posedge clk) begin
      if (!reset || flush) sb_q.delete();
      else if (in_valid && m_in_ready) sb_q.push_back(in_data);
   end

   // Monitor: compare against the model mid-cycle, consume the head on out_fire
   always @(negedge clk) begin : monitor
      int n;
      n = sb_q.size();
      m_in_ready = (n < 2);
      check("occupancy", 32'(occupancy), 32'(n));
      check("in_ready",  32'(in_ready),  32'(n < 2));
      check("out_valid", 32'(out_valid), 32'(n > 0));
      check("out_data",  32'(out_data),  32'((n > 0) ? sb_q[0] : NOP));
      if (n > 0 && out_ready) void'(sb_q.pop_front());
   end

   task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit f);
      @(posedge clk);
      #3;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      #1 reset = 1'b0;
      #1 check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset in_ready", 32'(in_ready), 32'd1);
      cyc(0, '0, 0, 0);
      reset = 1'b1;

      // streaming
      for (int i = 1; i <= 10; i++) cyc(1, W'(i), 1, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);

      // stall absorb
      cyc(1, W'(12'h0A5), 0, 0);
      cyc(1, W'(12'h05A), 0, 0);
      cyc(0, '0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);

      // simultaneous fire in ONE
      cyc(1, W'(12'h111), 0, 0);
      cyc(1, W'(12'h222), 1, 0);
      cyc(0, '0, 0, 0);
      cyc(0, '0, 1, 0);

      // flush in TWO, then flush from ONE with a word offered
      cyc(1, W'(12'h001), 0, 0);
      cyc(1, W'(12'h002), 0, 0);
      cyc(1, W'(12'h333), 0, 1);
      cyc(1, W'(12'h444), 0, 0);
      cyc(1, W'(12'h333), 1, 1);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);

      // async reset while in TWO
      cyc(1, W'(12'h0C1), 0, 0);
      cyc(1, W'(12'h0C2), 0, 0);
      cyc(0, '0, 0, 0);
      @(posedge clk);
      #3;
      reset = 1'b0;
      sb_q.delete();
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst out_data",  32'(out_data),  32'(NOP));
      check("async rst occupancy", 32'(occupancy), 32'd0);
      check("async rst in_ready",  32'(in_ready),  32'd1);
      cyc(1, W'(12'h7FF), 1, 0);
      reset = 1'b1;
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);

      // random traffic with sparse flush
      for (int i = 0; i < 10000; i++)
         cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 31) == 0));
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      cyc(0, '0, 1, 0);
      @(posedge clk);
      #3;
      check("drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
